// File: rtl/rv32i_mem_stage.sv
// RV32I memory-access stage: passes ALU results through, runs load/store
// transactions on the data bus with stall and timeout, and extends load data.
module rv32i_mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_we,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  output logic        mem_we,
  output logic [4:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        stall_req,
  output logic        misalign,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack
);

  // Counter only needs to hold 0..TIMEOUT-1; the abort fires on the edge it would reach TIMEOUT.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        bwe_q, bwe_d;
  logic [31:0] baddr_q, baddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] bwdata_q, bwdata_d;

  logic is_load, is_store, is_byte, is_half, is_word, is_unsigned, is_mem, misaligned;
  logic [3:0]  be_c;
  logic [31:0] store_lane, load_lane, load_ext;
  logic        mem_we_c, stall_c, mis_c;
  logic [31:0] mem_wdata_c;

  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_byte     = 1'b0;
    is_half     = 1'b0;
    is_word     = 1'b0;
    is_unsigned = 1'b0;
    case (ex_mem_op)
      4'd1: begin is_load = 1'b1;  is_byte = 1'b1; end
      4'd2: begin is_load = 1'b1;  is_half = 1'b1; end
      4'd3: begin is_load = 1'b1;  is_word = 1'b1; end
      4'd4: begin is_load = 1'b1;  is_byte = 1'b1; is_unsigned = 1'b1; end
      4'd5: begin is_load = 1'b1;  is_half = 1'b1; is_unsigned = 1'b1; end
      4'd6: begin is_store = 1'b1; is_byte = 1'b1; end
      4'd7: begin is_store = 1'b1; is_half = 1'b1; end
      4'd8: begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = (is_half & ex_mem_addr[0]) | (is_word & (|ex_mem_addr[1:0]));

  always_comb begin
    be_c       = 4'b1111;
    store_lane = ex_store_data;
    if (is_byte) begin
      be_c       = 4'b0001 << ex_mem_addr[1:0];
      store_lane = {4{ex_store_data[7:0]}};
    end else if (is_half) begin
      be_c       = 4'b0011 << ex_mem_addr[1:0];
      store_lane = {2{ex_store_data[15:0]}};
    end
  end

  // Load buffer holds the full word; the lane is picked from the still-stable EX address.
  assign load_lane = rdata_q >> {ex_mem_addr[1:0], 3'b000};

  always_comb begin
    load_ext = load_lane;
    if (is_byte) load_ext = {{24{load_lane[7] & ~is_unsigned}}, load_lane[7:0]};
    else if (is_half) load_ext = {{16{load_lane[15] & ~is_unsigned}}, load_lane[15:0]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_d       = req_q;
    bwe_d       = bwe_q;
    baddr_d     = baddr_q;
    be_d        = be_q;
    bwdata_d    = bwdata_q;
    mem_we_c    = 1'b0;
    mem_wdata_c = ex_wdata;
    stall_c     = 1'b0;
    mis_c       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!is_mem) begin
          mem_we_c = ex_we;
        end else if (misaligned) begin
          mis_c = 1'b1;
        end else begin
          stall_c  = 1'b1;
          state_d  = S_REQ;
          cnt_d    = '0;
          req_d    = 1'b1;
          bwe_d    = is_store;
          baddr_d  = {ex_mem_addr[31:2], 2'b00};
          be_d     = be_c;
          bwdata_d = store_lane;
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        if (dbus_ack) begin
          rdata_d = dbus_rdata;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        mem_wdata_c = load_ext;
        if (is_load && !err_q) mem_we_c = ex_we;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      bwe_q    <= 1'b0;
      baddr_q  <= '0;
      be_q     <= '0;
      bwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      req_q    <= req_d;
      bwe_q    <= bwe_d;
      baddr_q  <= baddr_d;
      be_q     <= be_d;
      bwdata_q <= bwdata_d;
    end
  end

  assign mem_we     = rst ? 1'b0  : mem_we_c;
  assign mem_waddr  = rst ? 5'd0  : ex_waddr;
  assign mem_wdata  = rst ? 32'd0 : mem_wdata_c;
  assign stall_req  = rst ? 1'b0  : stall_c;
  assign misalign   = rst ? 1'b0  : mis_c;
  assign bus_err    = rst ? 1'b0  : (state_q == S_DONE) & err_q;
  assign dbus_req   = rst ? 1'b0  : req_q;
  assign dbus_we    = rst ? 1'b0  : bwe_q;
  assign dbus_addr  = rst ? 32'd0 : baddr_q;
  assign dbus_be    = rst ? 4'd0  : be_q;
  assign dbus_wdata = rst ? 32'd0 : bwdata_q;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Scoreboard bench for rv32i_mem_stage: stimulus pushes expected write-back and
// bus requests into queues, two monitors pop and compare as the DUT presents them.
module tb_rv32i_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        stall_req, misalign, bus_err;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;

  rv32i_mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .stall_req(stall_req), .misalign(misalign), .bus_err(bus_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mis;
    logic        berr;
  } commit_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          len;
  } bus_t;

  commit_t cq[$];
  bus_t    bq[$];
  int      checks = 0;
  int      errors = 0;
  logic    mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input int op);
    if (op == 1 || op == 4 || op == 6) return 1;
    if (op == 2 || op == 5 || op == 7) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ext_model(input int op, input logic [31:0] addr, input logic [31:0] rd);
    int     n;
    int     off;
    longint v;
    n   = nbytes(op);
    off = int'(addr % 4);
    v   = longint'(rd >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
    if ((op == 1 || op == 2) && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  // Commit monitor: every non-stalled cycle is one retired instruction.
  commit_t e;
  always @(negedge clk) begin
    if (!rst && mon_en && !stall_req) begin
      if (cq.size() == 0) chk("commit_unexpected", 1, 0);
      else begin
        e = cq.pop_front();
        chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
        if (e.we) begin
          chk("mem_waddr", {27'd0, mem_waddr}, {27'd0, e.wa});
          chk("mem_wdata", mem_wdata, e.wd);
        end
        chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
        chk("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
      end
    end
  end

  // Bus monitor: checks request contents on the rising cycle and length on the fall.
  bus_t cur;
  logic cur_v = 1'b0;
  logic req_prev = 1'b0;
  int   run = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (dbus_req && !req_prev && mon_en) begin
        if (bq.size() == 0) chk("bus_unexpected", 1, 0);
        else begin
          cur   = bq.pop_front();
          cur_v = 1'b1;
          run   = 0;
          chk("dbus_addr", dbus_addr, cur.addr);
          chk("dbus_be", {28'd0, dbus_be}, {28'd0, cur.be});
          chk("dbus_we", {31'd0, dbus_we}, {31'd0, cur.we});
          if (cur.we) chk("dbus_wdata", dbus_wdata, cur.wdata);
        end
      end
      if (dbus_req) run++;
      if (!dbus_req && req_prev && cur_v) begin
        chk("req_len", run, cur.len);
        cur_v = 1'b0;
      end
    end
    req_prev = dbus_req;
  end

  // ackc: REQ cycle index that gets the ack; 0 or >TO means no ack in time.
  task automatic issue(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] rd, input int ackc);
    bit      is_ld, is_st, mis;
    int      n, w, stalls, cyc;
    commit_t c;
    bus_t    b;
    is_ld = (op >= 1 && op <= 5);
    is_st = (op >= 6 && op <= 8);
    n     = nbytes(op);
    mis   = (is_ld || is_st) && (addr % n != 0);
    w     = (ackc == 0 || ackc > TO) ? TO : ackc;
    c.we = 1'b0; c.wa = wa; c.wd = wd; c.mis = 1'b0; c.berr = 1'b0;
    if (!is_ld && !is_st) c.we = we;
    else if (mis) c.mis = 1'b1;
    else if (w == TO && (ackc == 0 || ackc > TO)) c.berr = 1'b1;
    else if (is_ld) begin c.we = we; c.wd = ext_model(op, addr, rd); end
    cq.push_back(c);
    if ((is_ld || is_st) && !mis) begin
      b.addr  = addr - (addr % 4);
      b.be    = 4'(((1 << n) - 1) << (addr % 4));
      b.we    = is_st;
      b.wdata = (n == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                (n == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
      b.len   = w;
      bq.push_back(b);
    end
    ex_mem_op     = 4'(op);
    ex_mem_addr   = addr;
    ex_store_data = sdata;
    ex_we         = we;
    ex_waddr      = wa;
    ex_wdata      = wd;
    dbus_ack      = 1'($urandom % 2);
    dbus_rdata    = $urandom;
    stalls = 0;
    cyc    = 0;
    forever begin
      @(negedge clk);
      if (!stall_req) break;
      stalls++;
      @(posedge clk); #1;
      cyc++;
      dbus_ack   = (cyc == ackc);
      dbus_rdata = dbus_ack ? rd : $urandom;
      if (cyc > 20) begin
        chk("stall_timeout", 1, 0);
        break;
      end
    end
    chk("stall_cycles", stalls, ((is_ld || is_st) && !mis) ? 1 + w : 0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
  endtask

  initial begin
    int op;
    logic [31:0] a;
    rst = 1'b1; ex_we = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h5555_AAAA;
    ex_mem_op = 4'd0; ex_mem_addr = 32'h0; ex_store_data = 32'h0;
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_waddr", {27'd0, mem_waddr}, 0);
    chk("rst_dbus_req", {31'd0, dbus_req}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    issue(0, 32'h0000_0040, 32'h0, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 0);
    issue(1, 32'h0000_1003, 32'h0, 1'b1, 5'd3, 32'h0, 32'h80FF_7F01, 1);
    issue(4, 32'h0000_1003, 32'h0, 1'b1, 5'd3, 32'h0, 32'h80FF_7F01, 1);
    issue(7, 32'h0000_2002, 32'hDEAD_BEEF, 1'b1, 5'd4, 32'h0, 32'h0, 3);
    issue(3, 32'h0000_0006, 32'h0, 1'b1, 5'd6, 32'h0, 32'h0, 1);
    issue(3, 32'h0000_0100, 32'h0, 1'b1, 5'd7, 32'h0, 32'h1111_2222, 0);
    issue(2, 32'h0000_0302, 32'h0, 1'b1, 5'd8, 32'h0, 32'h8123_4567, 2);

    // Reset in the second REQ cycle; the ack that follows must be ignored.
    mon_en        = 1'b0;
    ex_mem_op     = 4'd3;
    ex_mem_addr   = 32'h0000_0400;
    ex_we         = 1'b1;
    ex_waddr      = 5'd10;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", {31'd0, dbus_req}, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_req", {31'd0, dbus_req}, 0);
    chk("rst_req_stall", {31'd0, stall_req}, 0);
    chk("rst_req_be", {28'd0, dbus_be}, 0);
    chk("rst_req_addr", dbus_addr, 0);
    chk("rst_req_mem_we", {31'd0, mem_we}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ex_mem_op  = 4'd0;
    ex_we      = 1'b1;
    ex_waddr   = 5'd7;
    ex_wdata   = 32'h0000_CAFE;
    dbus_ack   = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("post_rst_req", {31'd0, dbus_req}, 0);
    chk("post_rst_stall", {31'd0, stall_req}, 0);
    chk("post_rst_mem_we", {31'd0, mem_we}, 1);
    chk("post_rst_wdata", mem_wdata, 32'h0000_CAFE);
    chk("post_rst_bus_err", {31'd0, bus_err}, 0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    chk("post_rst_req2", {31'd0, dbus_req}, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    for (int i = 0; i < 200; i++) begin
      op = int'($urandom % 16);
      a  = $urandom;
      if ($urandom % 3 != 0) a[1:0] = 2'(($urandom % 4) & ((op == 2 || op == 5 || op == 7) ? 2 : (op == 3 || op == 8) ? 0 : 3));
      issue(op, a, $urandom, 1'($urandom % 2), 5'($urandom), $urandom, $urandom,
            int'($urandom_range(0, TO + 1)));
    end

    mon_en = 1'b0;
    chk("commit_queue_empty", cq.size(), 0);
    chk("bus_queue_empty", bq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv32i_mem_stage.md
# rv32i_mem_stage

Memory-access stage of the RV32I five-stage pipeline, between the EX/MEM register and the MEM/WB register. Non-memory instructions pass their ALU result and write-back controls straight through. Loads and stores run a request/acknowledge transaction on the data bus and stall the front of the pipeline until it completes. Load data is byte-selected and sign/zero-extended before it goes to MEM/WB.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of REQ cycles without `dbus_ack` before the access is aborted.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `ex_we` in 1: register write enable from EX/MEM.
- `ex_waddr` in 5: destination register.
- `ex_wdata` in 32: ALU result.
- `ex_mem_op` in 4: memory operation. 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 are treated as NONE.
- `ex_mem_addr` in 32: effective address.
- `ex_store_data` in 32: rs2 value for stores.
- `mem_we` out 1: write enable to MEM/WB.
- `mem_waddr` out 5: destination register to MEM/WB.
- `mem_wdata` out 32: write-back data to MEM/WB.
- `stall_req` out 1: hold the PC, IF/ID, ID/EX and EX/MEM registers.
- `misalign` out 1: one-cycle pulse on a misaligned access.
- `bus_err` out 1: one-cycle pulse on a bus timeout.
- `dbus_req` out 1: bus request (registered).
- `dbus_we` out 1: bus write (registered).
- `dbus_addr` out 32: word address, `{addr[31:2],2'b00}` (registered).
- `dbus_be` out 4: byte enables (registered).
- `dbus_wdata` out 32: store data placed in its lane (registered).
- `dbus_rdata` in 32: read data, valid when `dbus_ack`=1.
- `dbus_ack` in 1: access complete.

## Operation
- **Reset:** while `rst`=1, all outputs are forced to 0 combinationally. At the clock edge the state goes to IDLE, the timeout counter and load buffer clear, and any bus request is dropped.
- **FSM states:** IDLE, REQ, DONE.
- **IDLE, op NONE:**
  - `mem_we/waddr/wdata` = `ex_we/waddr/wdata`; `stall_req`=0.
- **IDLE, misaligned op:**
  - Misaligned means `addr[0]`=1 for LH/LHU/SH, or `addr[1:0]`≠0 for LW/SW.
  - Outputs: `misalign`=1, `mem_we`=0, `stall_req`=0. No bus access; stay in IDLE.
- **IDLE, aligned load/store:**
  - `stall_req`=1, `mem_we`=0.
  - Next state is REQ. On the same edge, `dbus_req`, `dbus_we`, `dbus_addr`, `dbus_be` and `dbus_wdata` are registered, and the counter is cleared.
- **Byte enables:**
  - Byte ops: `4'b0001<<addr[1:0]`.
  - Halfword ops: `4'b0011<<addr[1:0]`.
  - Word ops: `4'b1111`.
- **Store data lanes:** SB replicates byte 0 to all four lanes. SH replicates the low half to both halves. SW passes the data unchanged.
- **REQ:**
  - Outputs: `stall_req`=1, `mem_we`=0; the `dbus_*` outputs stay stable.
  - On an edge where `dbus_ack`=1: capture `dbus_rdata` into the load buffer, clear `dbus_req`, go to DONE.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT` with no ack: clear `dbus_req`, set the error flag, go to DONE.
- **DONE:**
  - Outputs: `stall_req`=0 and `mem_waddr`=`ex_waddr`.
  - Loads without error: `mem_we`=`ex_we`; `mem_wdata` is the extended lane data.
  - Stores, or after an error: `mem_we`=0.
  - `bus_err`=1 in this cycle if the error flag is set.
  - Next state is IDLE; the error flag clears.
- **Load extension:**
  - The byte or halfword is selected by `addr[1:0]`.
  - LB and LH sign-extend from bit 7 or bit 15; LBU and LHU zero-extend; LW is passed as-is.
- **Ignored bus activity:** `dbus_ack` is ignored in IDLE and DONE. `dbus_rdata` is ignored without an ack.
- **Upstream rule:** EX/MEM holds all `ex_*` inputs stable while `stall_req`=1. The block re-samples `ex_*` in DONE.

## Timing
- `mem_*`, `stall_req` and `misalign` are combinational from state and `ex_*`. `dbus_*` and `bus_err` change only on clock edges, except the forced zero during reset.
- A memory op takes 2+W cycles, where W is the number of REQ cycles (≥1). The minimum is 3 cycles: IDLE, REQ with ack, DONE. MEM/WB captures the result at the end of DONE.
- If the same instruction is still present after DONE, it is not re-executed: EX/MEM advances on that edge because `stall_req`=0 in DONE.
- Back-to-back memory ops: the second op's IDLE cycle immediately follows the first op's DONE.
- The timeout aborts after exactly `TIMEOUT` REQ cycles with no ack.
- `rst` asserted during REQ: `dbus_req`=0 immediately (forced) and stays 0 after the edge. No DONE cycle occurs and no write-back is issued.

## Test plan
- ALU op: `ex_mem_op`=0, `ex_we`=1, `waddr`=5, `wdata`=0x1234 → same cycle `mem_we`=1, `waddr`=5, `wdata`=0x1234, `stall_req`=0.
- LB at 0x1003, `dbus_rdata`=0x80FF_7F01, ack in the first REQ cycle → `dbus_be`=1000, `addr`=0x1000; `stall_req` high for 2 cycles; DONE `mem_wdata`=0xFFFF_FF80. Repeat with LBU → 0x0000_0080.
- SH at 0x2002, data 0xDEAD_BEEF, ack after 3 REQ cycles → `dbus_we`=1, `be`=1100, `dbus_wdata`=0xBEEF_BEEF; `stall_req` high for 4 cycles; DONE `mem_we`=0.
- LW at 0x0000_0006 → `misalign` pulse for 1 cycle, `mem_we`=0, no `dbus_req`, `stall_req`=0.
- LW, `TIMEOUT`=4, ack never given → `dbus_req` high for 4 cycles; DONE cycle has `bus_err`=1 and `mem_we`=0; afterwards IDLE.
- Reset asserted in the second REQ cycle, ack arriving on the following cycle → all outputs 0 during reset, state IDLE, no write-back, late ack ignored.
